cordic_prerotate: RTL and testbench

- Input-conditioning stage that sits directly upstream of the first CORDIC micro-rotation stage.
- Accepts a vector (x, y) and a binary-angle target z through a valid/ready handshake.
- Pre-rotates by ±90° so the residual angle lies within [-π/2, +π/2], the convergence range of the micro-rotation chain.
- Two-stage registered pipeline with backpressure; output feeds the first micro-rotation stage with i = 0.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_pipe_reg.sv | 35 +++
 rtl/cordic_prerotate.sv | 97 +++++++++
 tb/tb_cordic_prerotate.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: widths, binary-angle constants, quadrant codes,
// stage payload types and the saturating negate used by every rotation stage.
package cordic_pkg;

   localparam int W = 32;

   // Full circle is 2^W, so the most negative angle stands for -pi.
   localparam logic signed [W-1:0] HALF_PI     = 32'sh4000_0000;
   localparam logic signed [W-1:0] NEG_HALF_PI = 32'shC000_0000;
   localparam logic signed [W-1:0] PI          = 32'sh8000_0000;

   typedef logic [1:0] quad_t;
   localparam quad_t QUAD_NONE  = 2'b00;
   localparam quad_t QUAD_POS90 = 2'b01;
   localparam quad_t QUAD_NEG90 = 2'b10;

   typedef struct packed {
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic signed [W-1:0] z;
      quad_t               quad;
   } s1_beat_t;

   typedef struct packed {
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic signed [W-1:0] z;
      quad_t               quad;
      logic                sat;
   } s2_beat_t;

   // Returns {saturated, -a}; the most negative value clamps to the most positive.
   function automatic logic [W:0] sat_neg(input logic signed [W-1:0] a);
      if (a == PI) begin
         return {1'b1, 1'b0, {(W-1){1'b1}}};
      end
      return {1'b0, -a};
   endfunction

endpackage

// File: rtl/cordic_pipe_reg.sv
// Generic valid/ready register slice. Loads whenever it is empty or its
// content is leaving, so a bubble is filled even while downstream stalls.
module cordic_pipe_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o
);

   logic          valid_q;
   logic [DW-1:0] data_q;
   logic          load;

   assign load    = !valid_q || ready_i;
   assign ready_o = load;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

endmodule

// File: rtl/cordic_prerotate.sv
// Pre-rotation by +/-90 degrees so the residual angle lands in [-pi/2, +pi/2]
// ahead of the first micro-rotation. Stage 1 classifies, stage 2 rotates.
module cordic_prerotate
   import cordic_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] y_in,
   input  logic [W-1:0] z_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x_out,
   output logic [W-1:0] y_out,
   output logic [W-1:0] z_out,
   output logic [1:0]   quad_out,
   output logic         sat_out
);

   s1_beat_t s1_d;
   s1_beat_t s1_q;
   s2_beat_t s2_d;
   s2_beat_t s2_q;
   logic     s1_valid;
   logic     s2_load;
   logic [W:0] neg_x;
   logic [W:0] neg_y;

   // Exactly +/-pi/2 is already in range and stays unrotated.
   always_comb begin
      s1_d.x    = x_in;
      s1_d.y    = y_in;
      s1_d.z    = z_in;
      s1_d.quad = QUAD_NONE;
      if ($signed(z_in) > HALF_PI) begin
         s1_d.quad = QUAD_POS90;
      end else if ($signed(z_in) < NEG_HALF_PI) begin
         s1_d.quad = QUAD_NEG90;
      end
   end

   always_comb begin
      neg_x     = sat_neg(s1_q.x);
      neg_y     = sat_neg(s1_q.y);
      s2_d.x    = s1_q.x;
      s2_d.y    = s1_q.y;
      s2_d.z    = s1_q.z;
      s2_d.quad = s1_q.quad;
      s2_d.sat  = 1'b0;
      case (s1_q.quad)
         QUAD_POS90: begin
            s2_d.x   = neg_y[W-1:0];
            s2_d.y   = s1_q.x;
            s2_d.z   = s1_q.z - HALF_PI;
            s2_d.sat = neg_y[W];
         end
         QUAD_NEG90: begin
            s2_d.x   = s1_q.y;
            s2_d.y   = neg_x[W-1:0];
            s2_d.z   = s1_q.z + HALF_PI;
            s2_d.sat = neg_x[W];
         end
         default: ;
      endcase
   end

   cordic_pipe_reg #(.DW($bits(s1_beat_t))) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (in_valid),
      .ready_o (in_ready),
      .data_i  (s1_d),
      .valid_o (s1_valid),
      .ready_i (s2_load),
      .data_o  (s1_q)
   );

   cordic_pipe_reg #(.DW($bits(s2_beat_t))) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (s1_valid),
      .ready_o (s2_load),
      .data_i  (s2_d),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .data_o  (s2_q)
   );

   assign x_out    = s2_q.x;
   assign y_out    = s2_q.y;
   assign z_out    = s2_q.z;
   assign quad_out = s2_q.quad;
   assign sat_out  = s2_q.sat;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Bench for cordic_prerotate: directed corner beats, backpressure, random
// traffic and mid-stream reset, all scored against an arithmetic reference.
module tb_cordic_prerotate;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x_in, y_in, z_in, x_out, y_out, z_out;
   logic [1:0]  quad_out;
   logic        sat_out;

   always #5 clk = ~clk;

   cordic_prerotate dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out),
      .quad_out  (quad_out),
      .sat_out   (sat_out)
   );

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [1:0]  q;
      logic        s;
   } beat_t;

   beat_t       exp_q[$];
   int          stamp_q[$];
   int          n_chk = 0, n_pass = 0, cyc = 0, n_out = 0;
   bit          lat_chk = 0, hold_v = 0, last_acc = 0;
   logic [31:0] hold_x, hold_y, hold_z;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference: rotation chosen from the signed angle, negation clamped to the int32 max.
   function automatic beat_t model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      longint sx, sy, sz, nx, ny, nz, hp, mx;
      beat_t  b;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sz = longint'($signed(z));
      hp = 64'sd1073741824;
      mx = 64'sd2147483647;
      nx = sx; ny = sy; nz = sz;
      b.q = 2'd0;
      b.s = 1'b0;
      if (sz > hp) begin
         nx = -sy; ny = sx; nz = sz - hp; b.q = 2'd1;
      end else if (sz < -hp) begin
         nx = sy; ny = -sx; nz = sz + hp; b.q = 2'd2;
      end
      if (nx > mx) begin nx = mx; b.s = 1'b1; end
      if (ny > mx) begin ny = mx; b.s = 1'b1; end
      b.x = nx[31:0];
      b.y = ny[31:0];
      b.z = nz[31:0];
      return b;
   endfunction

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h4000_0000;
         2: return 32'hC000_0000;
         3: return 32'h4000_0001;
         4: return 32'hBFFF_FFFF;
         5: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // One clock: score at the falling edge, then step past the rising edge.
   task automatic tick();
      beat_t b;
      int    st;
      @(negedge clk);
      if (out_valid && !out_ready) begin
         if (hold_v) begin
            chk("stall_x", x_out, hold_x);
            chk("stall_y", y_out, hold_y);
            chk("stall_z", z_out, hold_z);
         end
         hold_x = x_out; hold_y = y_out; hold_z = z_out; hold_v = 1;
      end else begin
         hold_v = 0;
      end
      if (out_valid && out_ready) begin
         chk("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            b  = exp_q.pop_front();
            st = stamp_q.pop_front();
            chk("x_out", x_out, b.x);
            chk("y_out", y_out, b.y);
            chk("z_out", z_out, b.z);
            chk("quad_out", quad_out, b.q);
            chk("sat_out", sat_out, b.s);
            if (lat_chk) chk("latency", cyc - st, 2);
            n_out++;
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         exp_q.push_back(model(x_in, y_in, z_in));
         stamp_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      bit done = 0;
      x_in = x; y_in = y; z_in = z;
      in_valid = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         tick();
         done = last_acc;
      end
      if (!done) chk("accept_timeout", 0, 1);
      in_valid = 0;
   endtask

   initial begin
      int n_acc, out0;
      rst = 1; in_valid = 0; out_ready = 0;
      x_in = 0; y_in = 0; z_in = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_z", z_out, 0);
      chk("rst_quad", quad_out, 0);
      chk("rst_sat", sat_out, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 0;
      tick();

      // directed corners, one beat at a time, latency measured
      out_ready = 1;
      lat_chk = 1;
      send(32'd1000, 32'd0,   32'h2000_0000);
      repeat (3) tick();
      send(32'd1000, 32'd500, 32'h6000_0000);
      send(32'd1000, 32'd500, 32'h8000_0000);
      send(32'd1000, 32'd500, 32'h4000_0000);
      send(32'd1000, 32'd500, 32'hC000_0000);
      send(32'd0,    32'h8000_0000, 32'h7000_0000);
      send(32'h8000_0000, 32'd7, 32'h9000_0000);
      send(32'h8000_0000, 32'h8000_0000, 32'h4000_0001);
      send(-32'sd3,  32'd9,   32'hBFFF_FFFF);
      repeat (4) tick();
      lat_chk = 0;
      chk("directed_empty", exp_q.size(), 0);

      // backpressure: two accepts fill the pipe, then everything holds
      out_ready = 0;
      n_acc = 0;
      out0 = n_out;
      x_in = $urandom(); y_in = $urandom(); z_in = rv();
      in_valid = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (last_acc) begin
            n_acc++;
            x_in = $urandom(); y_in = $urandom(); z_in = rv();
         end
      end
      chk("bp_accepts", n_acc, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      out_ready = 1;
      for (int i = 0; i < 40 && n_acc < 5; i++) begin
         tick();
         if (last_acc) begin
            n_acc++;
            if (n_acc == 5) in_valid = 0;
            else begin x_in = $urandom(); y_in = $urandom(); z_in = rv(); end
         end
      end
      in_valid = 0;
      repeat (4) tick();
      chk("bp_count", n_out - out0, 5);
      chk("bp_empty", exp_q.size(), 0);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         x_in = rv(); y_in = rv(); z_in = rv();
         tick();
      end
      in_valid = 0;
      out_ready = 1;
      repeat (4) tick();
      chk("rand_drain", exp_q.size(), 0);

      // reset with both stages full discards the in-flight beats
      out_ready = 0;
      x_in = 32'd11; y_in = 32'd22; z_in = 32'h7000_0000;
      in_valid = 1;
      tick();
      tick();
      in_valid = 0;
      chk("rs_full_in_ready", in_ready, 0);
      #1;
      rst = 1;
      #1;
      chk("rs_out_valid", out_valid, 0);
      chk("rs_in_ready", in_ready, 1);
      exp_q.delete();
      stamp_q.delete();
      hold_v = 0;
      @(posedge clk);
      #1;
      rst = 0;
      out_ready = 1;
      out0 = n_out;
      tick();
      chk("rs_no_ghost", n_out - out0, 0);
      send(32'd777, 32'hFFFF_FF00, 32'hA000_0000);
      repeat (4) tick();
      chk("rs_count", n_out - out0, 1);
      chk("rs_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
